// File: rtl/deferred_check_collector.sv
// -----------------------------------------------------------------------------
// deferred_check_collector
//
// Receiving end of the deferred-assertion compare path. Each cycle it samples a
// compare request, classifies it as pass or fail using only the value settled at
// the clock edge, keeps saturating pass/fail/drop statistics and a cycle
// timestamp, and queues every failure as a record {a, b, ts} in a small FIFO.
// A downstream logger drains that FIFO through a valid/ready handshake.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   arm; when low, checks are ignored and the timestamp holds
//   clr        in   synchronous clear of counters, FIFO, timestamp, overflow
//   chk_valid  in   compare request this cycle
//   chk_a      in   left operand  [WIDTH]
//   chk_b      in   right operand [WIDTH]
//   fail_pulse out  one-cycle pulse per detected failure
//   pass_cnt   out  saturating pass count [CNT_W]
//   fail_cnt   out  saturating fail count [CNT_W]
//   drop_cnt   out  saturating count of records lost to a full FIFO [CNT_W]
//   overflow   out  sticky, set on first dropped record
//   rpt_valid  out  FIFO head valid
//   rpt_ready  in   downstream accepts head
//   rpt_a      out  failing chk_a at head [WIDTH]
//   rpt_b      out  failing chk_b at head [WIDTH]
//   rpt_ts     out  timestamp of failure at head [TS_W]
// -----------------------------------------------------------------------------
module deferred_check_collector #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16,
   parameter int TS_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             chk_valid,
   input  logic [WIDTH-1:0] chk_a,
   input  logic [WIDTH-1:0] chk_b,
   output logic             fail_pulse,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             overflow,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [WIDTH-1:0] rpt_a,
   output logic [WIDTH-1:0] rpt_b,
   output logic [TS_W-1:0]  rpt_ts
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int REC_W = 2 * WIDTH + TS_W;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state_reg, state_next;

   logic [TS_W-1:0]  ts_reg;
   logic [CNT_W-1:0] pass_cnt_reg;
   logic [CNT_W-1:0] fail_cnt_reg;
   logic [CNT_W-1:0] drop_cnt_reg;
   logic             overflow_reg;
   logic             fail_pulse_reg;
   logic [PTR_W-1:0] wptr_reg;
   logic [PTR_W-1:0] rptr_reg;
   logic [OCC_W-1:0] occ_reg;

   logic [REC_W-1:0] mem [DEPTH];
   logic [REC_W-1:0] head;

   logic accept;
   logic chk_pass;
   logic chk_fail;
   logic full;
   logic pop;
   logic push_ok;
   logic drop;

   // ---------------------------------------------------------------------------
   // Control state: ACTIVE simply mirrors the registered arm input.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (en)  state_next = ACTIVE;
         ACTIVE:  if (!en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Check classification. Written as if/else so that an X or Z equality result
   // falls into the fail branch: only a definite 1 counts as a pass.
   // ---------------------------------------------------------------------------
   always_comb begin
      accept   = en && chk_valid && !clr;
      chk_pass = 1'b0;
      chk_fail = 1'b0;
      if (accept) begin
         if (chk_a == chk_b) begin
            chk_pass = 1'b1;
         end else begin
            chk_fail = 1'b1;
         end
      end
   end

   // rpt_valid comes straight from the occupancy register, so pop never feeds
   // back into valid combinationally. A full FIFO can still accept a push when
   // the head leaves on the same edge.
   always_comb begin
      full    = (occ_reg == OCC_W'(DEPTH));
      pop     = rpt_valid && rpt_ready && !clr;
      push_ok = chk_fail && (!full || pop);
      drop    = chk_fail && full && !pop;
   end

   // ---------------------------------------------------------------------------
   // Statistics, timestamp and FIFO bookkeeping.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_reg         <= '0;
         pass_cnt_reg   <= '0;
         fail_cnt_reg   <= '0;
         drop_cnt_reg   <= '0;
         overflow_reg   <= 1'b0;
         fail_pulse_reg <= 1'b0;
         wptr_reg       <= '0;
         rptr_reg       <= '0;
         occ_reg        <= '0;
      end else if (clr) begin
         ts_reg         <= '0;
         pass_cnt_reg   <= '0;
         fail_cnt_reg   <= '0;
         drop_cnt_reg   <= '0;
         overflow_reg   <= 1'b0;
         fail_pulse_reg <= 1'b0;
         wptr_reg       <= '0;
         rptr_reg       <= '0;
         occ_reg        <= '0;
      end else begin
         if (en) begin
            ts_reg <= ts_reg + TS_W'(1);
         end
         if (chk_pass && (pass_cnt_reg != '1)) begin
            pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
         end
         if (chk_fail && (fail_cnt_reg != '1)) begin
            fail_cnt_reg <= fail_cnt_reg + CNT_W'(1);
         end
         if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
         fail_pulse_reg <= chk_fail;
         if (push_ok) begin
            wptr_reg <= wptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rptr_reg <= rptr_reg + PTR_W'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   // Record storage; the timestamp stored is the value before this edge's
   // increment. No reset needed: unread entries are masked at the outputs.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr_reg] <= {chk_a, chk_b, ts_reg};
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. Head fields read as zero whenever the FIFO is empty, which keeps
   // them clean after reset and after clr.
   // ---------------------------------------------------------------------------
   assign head       = mem[rptr_reg];
   assign rpt_valid  = (occ_reg != '0);
   assign rpt_a      = rpt_valid ? head[REC_W-1 -: WIDTH]     : '0;
   assign rpt_b      = rpt_valid ? head[TS_W+WIDTH-1 -: WIDTH] : '0;
   assign rpt_ts     = rpt_valid ? head[TS_W-1:0]             : '0;
   assign fail_pulse = fail_pulse_reg;
   assign pass_cnt   = pass_cnt_reg;
   assign fail_cnt   = fail_cnt_reg;
   assign drop_cnt   = drop_cnt_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_deferred_check_collector.sv
// -----------------------------------------------------------------------------
// tb_deferred_check_collector
//
// Directed-vector bench for deferred_check_collector. A queue-based behavioural
// model tracks what every output must be; one compare process checks all outputs
// against it on each falling edge, and hand-computed literal expectations pin the
// model at key points of each scenario. The counter width is reduced so that the
// saturation scenario runs in about a thousand cycles.
// -----------------------------------------------------------------------------
module tb_deferred_check_collector;

   localparam int WIDTH = 8;
   localparam int CNT_W = 10;
   localparam int TS_W  = 32;
   localparam int DEPTH = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             clr = 1'b0;
   logic             chk_valid = 1'b0;
   logic [WIDTH-1:0] chk_a = '0;
   logic [WIDTH-1:0] chk_b = '0;
   logic             rpt_ready = 1'b0;
   logic             fail_pulse;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             overflow;
   logic             rpt_valid;
   logic [WIDTH-1:0] rpt_a;
   logic [WIDTH-1:0] rpt_b;
   logic [TS_W-1:0]  rpt_ts;

   always #5 clk = ~clk;

   deferred_check_collector #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W),
      .TS_W (TS_W),
      .DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .chk_valid (chk_valid),
      .chk_a     (chk_a),
      .chk_b     (chk_b),
      .fail_pulse(fail_pulse),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt),
      .drop_cnt  (drop_cnt),
      .overflow  (overflow),
      .rpt_valid (rpt_valid),
      .rpt_ready (rpt_ready),
      .rpt_a     (rpt_a),
      .rpt_b     (rpt_b),
      .rpt_ts    (rpt_ts)
   );

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TS_W-1:0]  ts;
   } rec_t;

   rec_t            m_q[$];
   int unsigned     m_pass = 0;
   int unsigned     m_fail = 0;
   int unsigned     m_drop = 0;
   bit              m_ovf = 1'b0;
   bit              m_pulse = 1'b0;
   logic [TS_W-1:0] m_ts = '0;

   int checks = 0;
   int failures = 0;

   function automatic void model_reset();
      m_q.delete();
      m_pass  = 0;
      m_fail  = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
      m_pulse = 1'b0;
      m_ts    = '0;
   endfunction

   // One rising edge worth of behaviour, from the inputs present at that edge.
   function automatic void model_step();
      bit   do_pop;
      bit   do_push;
      rec_t r;
      if (!rst_n || clr) begin
         model_reset();
         return;
      end
      do_pop  = (m_q.size() != 0) && rpt_ready;
      do_push = 1'b0;
      m_pulse = 1'b0;
      r.a = chk_a;
      r.b = chk_b;
      r.ts = m_ts;
      if (en && chk_valid) begin
         if ((chk_a == chk_b) === 1'b1) begin
            if (m_pass < CNT_MAX) m_pass++;
         end else begin
            if (m_fail < CNT_MAX) m_fail++;
            m_pulse = 1'b1;
            do_push = 1'b1;
         end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back(r);
         end else begin
            if (m_drop < CNT_MAX) m_drop++;
            m_ovf = 1'b1;
         end
      end
      if (en) m_ts = m_ts + 1'b1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".fail_pulse"}, 64'(fail_pulse), 64'd0);
      check({tag, ".pass_cnt"},   64'(pass_cnt),   64'd0);
      check({tag, ".fail_cnt"},   64'(fail_cnt),   64'd0);
      check({tag, ".drop_cnt"},   64'(drop_cnt),   64'd0);
      check({tag, ".overflow"},   64'(overflow),   64'd0);
      check({tag, ".rpt_valid"},  64'(rpt_valid),  64'd0);
      check({tag, ".rpt_a"},      64'(rpt_a),      64'd0);
      check({tag, ".rpt_b"},      64'(rpt_b),      64'd0);
      check({tag, ".rpt_ts"},     64'(rpt_ts),     64'd0);
   endtask

   // Advance one rising edge, update the model, then step off the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Compare process: every falling edge, all outputs against the model.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      check("cmp.fail_pulse", 64'(fail_pulse), 64'(m_pulse));
      check("cmp.pass_cnt",   64'(pass_cnt),   64'(m_pass));
      check("cmp.fail_cnt",   64'(fail_cnt),   64'(m_fail));
      check("cmp.drop_cnt",   64'(drop_cnt),   64'(m_drop));
      check("cmp.overflow",   64'(overflow),   64'(m_ovf));
      check("cmp.rpt_valid",  64'(rpt_valid),  64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("cmp.rpt_a",  64'(rpt_a),  64'(m_q[0].a));
         check("cmp.rpt_b",  64'(rpt_b),  64'(m_q[0].b));
         check("cmp.rpt_ts", 64'(rpt_ts), 64'(m_q[0].ts));
         if (rpt_ready && rst_n) begin
            $display("record a=%0h b=%0h ts=%0d", rpt_a, rpt_b, rpt_ts);
         end
      end else begin
         check("cmp.rpt_a_idle",  64'(rpt_a),  64'd0);
         check("cmp.rpt_b_idle",  64'(rpt_b),  64'd0);
         check("cmp.rpt_ts_idle", 64'(rpt_ts), 64'd0);
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   initial begin
      // Reset
      tick();
      tick();
      #2 rst_n = 1'b1;
      check_all_zero("reset");

      // Four checks, one failure, consumer ready
      en = 1'b1;
      rpt_ready = 1'b1;
      chk_valid = 1'b1;
      chk_a = 8'd5; chk_b = 8'd5; tick();
      check("t1.pulse0", 64'(fail_pulse), 64'd0);
      chk_a = 8'd3; chk_b = 8'd3; tick();
      check("t1.pulse1", 64'(fail_pulse), 64'd0);
      chk_a = 8'd7; chk_b = 8'd2; tick();
      check("t1.pulse2", 64'(fail_pulse), 64'd1);
      check("t1.valid",  64'(rpt_valid),  64'd1);
      check("t1.rpt_a",  64'(rpt_a),      64'd7);
      check("t1.rpt_b",  64'(rpt_b),      64'd2);
      check("t1.rpt_ts", 64'(rpt_ts),     64'd2);
      chk_a = 8'd0; chk_b = 8'd0; tick();
      check("t1.pulse3", 64'(fail_pulse), 64'd0);
      check("t1.pass",   64'(pass_cnt),   64'd3);
      check("t1.fail",   64'(fail_cnt),   64'd1);
      check("t1.drained", 64'(rpt_valid), 64'd0);
      chk_valid = 1'b0;

      // Six failures into a stalled FIFO, then drain
      clr = 1'b1; tick(); clr = 1'b0;
      rpt_ready = 1'b0;
      chk_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk_a = 8'h10 + 8'(i); chk_b = 8'h00; tick();
      end
      chk_valid = 1'b0;
      check("t2.fail", 64'(fail_cnt), 64'd6);
      check("t2.drop", 64'(drop_cnt), 64'd2);
      check("t2.ovf",  64'(overflow), 64'd1);
      rpt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t2.valid", 64'(rpt_valid), 64'd1);
         check("t2.ts",    64'(rpt_ts),    64'(k));
         check("t2.a",     64'(rpt_a),     64'(8'h10 + k));
         tick();
      end
      check("t2.empty", 64'(rpt_valid), 64'd0);

      // Full FIFO: push and pop on the same edge
      clr = 1'b1; tick(); clr = 1'b0;
      rpt_ready = 1'b0;
      chk_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_a = 8'h20 + 8'(i); chk_b = 8'h00; tick();
      end
      rpt_ready = 1'b1;
      chk_a = 8'h55; tick();
      chk_valid = 1'b0;
      check("t3.drop", 64'(drop_cnt), 64'd0);
      check("t3.ovf",  64'(overflow), 64'd0);
      for (int k = 1; k <= 4; k++) begin
         check("t3.valid", 64'(rpt_valid), 64'd1);
         check("t3.ts",    64'(rpt_ts),    64'(k));
         check("t3.a",     64'(rpt_a),     (k < 4) ? 64'(8'h20 + k) : 64'h55);
         tick();
      end
      check("t3.empty", 64'(rpt_valid), 64'd0);

      // Unknown operand, then disarmed checks while the FIFO drains
      clr = 1'b1; tick(); clr = 1'b0;
      rpt_ready = 1'b0;
      chk_valid = 1'b1;
      chk_a = 'x; chk_b = 8'h00; tick();
      chk_a = 8'd9; chk_b = 8'd1; tick();
      en = 1'b0;
      rpt_ready = 1'b1;
      chk_a = 8'd1; chk_b = 8'd2;
      repeat (3) tick();
      check("t4.drained", 64'(rpt_valid), 64'd1 - 64'd1);
      check("t4.drop",    64'(drop_cnt),  64'd0);
      en = 1'b1;
      rpt_ready = 1'b0;
      chk_a = 8'h33; chk_b = 8'h00; tick();
      chk_valid = 1'b0;
      check("t4.ts_frozen", 64'(rpt_ts), 64'd2);
      check("t4.a",         64'(rpt_a),  64'h33);
      rpt_ready = 1'b1; tick();

      // clr together with a failing check, two records queued, overflow set
      clr = 1'b1; tick(); clr = 1'b0;
      rpt_ready = 1'b0;
      chk_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk_a = 8'h40 + 8'(i); chk_b = 8'h00; tick();
      end
      chk_valid = 1'b0;
      rpt_ready = 1'b1;
      repeat (2) tick();
      rpt_ready = 1'b0;
      check("t5.ovf",  64'(overflow), 64'd1);
      check("t5.head", 64'(rpt_ts),   64'd2);
      chk_valid = 1'b1;
      chk_a = 8'h77; chk_b = 8'h00;
      clr = 1'b1; tick(); clr = 1'b0;
      chk_valid = 1'b0;
      check_all_zero("t5.clr");
      tick();
      check("t5.still_empty", 64'(rpt_valid), 64'd0);

      // Asynchronous reset mid-cycle with records queued
      chk_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk_a = 8'h60 + 8'(i); chk_b = 8'h00; tick();
      end
      chk_valid = 1'b0;
      check("t6.queued", 64'(rpt_valid), 64'd1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all_zero("t6.async");
      tick();
      tick();
      #3 rst_n = 1'b1;
      rpt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6.no_report", 64'(rpt_valid), 64'd0);
      end

      // Saturation of the fail counter
      clr = 1'b1; tick(); clr = 1'b0;
      chk_valid = 1'b1;
      chk_a = 8'hAA; chk_b = 8'h55;
      repeat (CNT_MAX) tick();
      check("t7.at_max", 64'(fail_cnt), 64'(CNT_MAX));
      tick();
      check("t7.hold",   64'(fail_cnt),   64'(CNT_MAX));
      check("t7.pulse",  64'(fail_pulse), 64'd1);
      check("t7.drop",   64'(drop_cnt),   64'd0);
      chk_valid = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/deferred_check_collector.md
# deferred_check_collector

Receiving end of the deferred-assertion compare path in the assertion test infrastructure. Each cycle it samples a compare request (`chk_a` vs `chk_b`) and classifies it as pass or fail with deferred semantics: only the settled value at the clock edge counts, so glitches within a cycle are never reported. It keeps saturating pass/fail statistics and a cycle timestamp. Every failure is queued as a record in a small FIFO, which a downstream logger drains through a valid/ready handshake.

## Interface
- `WIDTH`, 8, width of each compared operand
- `CNT_W`, 16, width of the pass, fail and drop counters
- `TS_W`, 32, width of the cycle timestamp
- `DEPTH`, 4, failure-record FIFO depth (power of two, ≥2)

- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, reset, asynchronous assert, active-low
- `en` in 1, arm; when low, checks are ignored and the timestamp freezes
- `clr` in 1, synchronous clear of counters, FIFO, timestamp and overflow
- `chk_valid` in 1, compare request this cycle
- `chk_a` in WIDTH, left operand
- `chk_b` in WIDTH, right operand
- `fail_pulse` out 1, one-cycle pulse per detected failure
- `pass_cnt` out CNT_W, saturating pass count
- `fail_cnt` out CNT_W, saturating fail count
- `drop_cnt` out CNT_W, saturating count of failure records lost to a full FIFO
- `overflow` out 1, sticky, set on first drop
- `rpt_valid` out 1, FIFO head valid
- `rpt_ready` in 1, downstream accepts head
- `rpt_a` out WIDTH, failing `chk_a` at head
- `rpt_b` out WIDTH, failing `chk_b` at head
- `rpt_ts` out TS_W, timestamp of failure at head

## Operation
- **Accepted check:** `en && chk_valid && !clr` at a rising edge.
- **Pass / fail rule:** an accepted check passes iff `(chk_a == chk_b)` evaluates to 1. A 0, X or Z result is a fail, matching deferred-assert semantics.
- **On pass:** `pass_cnt` increments, saturating at all-ones.
- **On fail:**
  - `fail_cnt` increments, saturating.
  - `fail_pulse` is high for the next cycle.
  - The record {`chk_a`, `chk_b`, `ts`} is pushed into the FIFO.
- **Timestamp `ts`:**
  - Internal counter, 0 after reset or `clr`.
  - Increments every cycle that `en` is high and `clr` is low.
  - Wraps modulo 2^TS_W.
  - A record stores the value of `ts` before that edge's increment.
- **FIFO:**
  - Circular buffer with read pointer, write pointer and an occupancy count of 0..DEPTH.
  - Pop occurs when `rpt_valid && rpt_ready`.
  - Push when full and no pop in the same cycle: the record is dropped, `drop_cnt` increments (saturating) and `overflow` is set. `fail_cnt` still counts the failure.
  - Push and pop in the same cycle when full: both occur, nothing is dropped, occupancy stays DEPTH.
  - Push and pop in the same cycle when empty: not possible, because head data is registered.
- **`clr`:**
  - Highest priority.
  - Zeroes all counters, `ts` and occupancy; clears `overflow`.
  - Discards any same-cycle check and pop.
  - `fail_pulse` is low the next cycle.
- **`en` low:** the FIFO still drains. Counters and `ts` hold.
- **Control state:** two states, IDLE and ACTIVE, with ACTIVE = `en` registered. No other state; behaviour is fully defined by the rules above.

## Timing
- **Reset values:** all outputs 0 (`fail_pulse`, counters, `overflow`, `rpt_valid`, `rpt_a`, `rpt_b`, `rpt_ts`). `ts`, occupancy and both pointers are 0.
- **Reset mid-operation:** asynchronously discards queued records; nothing is reported after `rst_n` rises.
- **Check latency:** a check sampled at edge N is visible at edge N+1:
  - `fail_pulse` is high during cycle N+1.
  - `pass_cnt` / `fail_cnt` are updated.
  - If the FIFO was empty, `rpt_valid` = 1 with the record on `rpt_a`/`rpt_b`/`rpt_ts`.
- **Handshake rules:**
  - Head data is stable while `rpt_valid && !rpt_ready`.
  - After a pop, the next record is presented on the following cycle.
  - Sustained throughput is one record per cycle.
- **`rpt_valid`** must not depend combinationally on `rpt_ready`.

## Test plan
- Reset, `en`=1, four checks (5,5), (3,3), (7,2), (0,0) on consecutive cycles with `rpt_ready`=1 → `pass_cnt`=3, `fail_cnt`=1. `fail_pulse` is high exactly on the cycle after the (7,2) sample. One record {7,2,ts=2} is observed.
- `rpt_ready`=0, six consecutive failing checks with DEPTH=4 → `fail_cnt`=6, `drop_cnt`=2, `overflow`=1. Raising `rpt_ready` drains exactly the first four records with ts 0,1,2,3 in order.
- FIFO full, `rpt_ready`=1 and a failing check on the same edge → no drop, occupancy stays 4, and the new record lands at the tail.
- `chk_a`=8'hXX, `chk_b`=8'h00 → counted as a fail and reported. Then `en`=0 for 3 cycles with failing checks → no count change and `ts` frozen; the FIFO still drains.
- `clr` asserted on the same edge as a failing check, with 2 records queued → everything reads 0 on the next cycle, including `rpt_valid`=0 and `overflow`=0.
- `rst_n` pulsed low mid-cycle while records are queued → all outputs 0 immediately; no record is reported after release.
- Saturation: force or pre-run to `fail_cnt`=2^CNT_W−1, then one more fail → `fail_cnt` holds at all-ones.
